// File: rtl/uart_rx_parity.sv
// uart_rx_parity: UART receiver driven by a 16x-oversampling s_tick strobe.
// Recovers a start bit, DBIT data bits (LSB first), an optional parity bit and
// the stop bit(s), then presents the word with a one-clock rx_done_tick.
// Build option: define UART_RX_PARITY_EN to expect a parity bit after the data
// bits; otherwise there is no parity state and parity_err is constant 0.
`timescale 1ns/1ps
module uart_rx_parity #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err
);

  localparam int SW = $clog2(SB_TICK);
  localparam int NW = $clog2(DBIT);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  // Tick counts at which the line is sampled: mid start bit, then one bit later.
  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic          ODD    = (PARITY_ODD != 0);

  logic            rx_meta_q, rx_s_q;
  logic [2:0]      state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic            p_q, p_d;
  logic            parity_err_q, parity_err_d;
`endif

  // Two-flop synchronizer for the asynchronous serial line; both flops idle high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Frame-recovery FSM; counters only move on s_tick, so a missing tick freezes it.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    b_d         = b_q;
    dout_d      = dout_q;
    done_d      = 1'b0;
    frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
    p_d          = p_q;
    parity_err_d = parity_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              // Line went high again before mid start bit: treat as a glitch.
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_d     = '0;
            p_d     = rx_s_q;
            state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            // Frame complete: publish word and flags together with the strobe.
            state_d     = IDLE;
            done_d      = 1'b1;
            dout_d      = b_q;
            frame_err_d = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
            parity_err_d = (^b_q) ^ p_q ^ ODD;
`endif
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, shift register and output registers; reset abandons any frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      n_q         <= '0;
      b_q         <= '0;
      dout_q      <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      p_q          <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      b_q         <= b_d;
      dout_q      <= dout_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      p_q          <= p_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = parity_err_q;
`else
  // Without a parity bit there is nothing to check; the polarity is irrelevant.
  assign parity_err   = ODD & 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_parity.sv
// Directed testbench for uart_rx_parity (default parameters, DBIT=8).
// Works in both builds; the parity scenarios follow UART_RX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_rx_parity;

  logic       clk;
  logic       reset_n;
  logic       s_tick;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       parity_err;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  // Done-pulse monitor
  int         done_cnt = 0;
  logic [7:0] cap_dout = 8'h00;
  logic       cap_pe   = 1'b0;
  logic       cap_fe   = 1'b0;

  uart_rx_parity dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .parity_err   (parity_err),
    .frame_err    (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // s_tick: one clock high out of every four
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) begin
      done_cnt <= done_cnt + 1;
      cap_dout <= dout;
      cap_pe   <= parity_err;
      cap_fe   <= frame_err;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input bit bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(pbit);
`else
    if (pbit === 1'bx) rx = 1'b1;
`endif
    if (bad_stop) begin
      // Low through the mid-bit sample, high before any restarted frame samples it.
      rx = 1'b0;
      repeat (48) @(negedge clk);
      rx = 1'b1;
      repeat (16) @(negedge clk);
    end else begin
      send_bit(1'b1);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h expected 00", dout); end
    checks++; if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", rx_done_tick); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rst_perr: got %b expected 0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b expected 0", frame_err); end
    reset_n = 1'b1;
    repeat (1000) @(negedge clk);
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL idle_no_done: got %0d pulses expected 0", done_cnt); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL idle_dout: got %h expected 00", dout); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL idle_ferr: got %b expected 0", frame_err); end
  endtask

  task automatic test_basic;
    int base;
    base = done_cnt;
    send_frame(8'hA5, 1'b0, 1'b0);
    repeat (64) @(negedge clk);
    checks++; if (done_cnt !== base + 1) begin errors++; $display("FAIL a5_pulses: got %0d expected %0d", done_cnt - base, 1); end
    checks++; if (cap_dout !== 8'hA5) begin errors++; $display("FAIL a5_dout: got %h expected a5", cap_dout); end
    checks++; if (cap_fe !== 1'b0) begin errors++; $display("FAIL a5_ferr: got %b expected 0", cap_fe); end
    checks++; if (cap_pe !== 1'b0) begin errors++; $display("FAIL a5_perr: got %b expected 0", cap_pe); end
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL a5_hold: got %h expected a5", dout); end
  endtask

  task automatic test_glitch;
    int base;
    base = done_cnt;
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (done_cnt !== base) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", done_cnt - base); end
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL glitch_dout: got %h expected a5", dout); end
    // A real frame right after proves the receiver is back in idle.
    send_frame(8'h69, 1'b0, 1'b0);
    repeat (64) @(negedge clk);
    checks++; if (done_cnt !== base + 1) begin errors++; $display("FAIL post_glitch_pulses: got %0d expected 1", done_cnt - base); end
    checks++; if (cap_dout !== 8'h69) begin errors++; $display("FAIL post_glitch_dout: got %h expected 69", cap_dout); end
  endtask

  task automatic test_parity;
    int base;
    base = done_cnt;
`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b0, 1'b0);
    repeat (64) @(negedge clk);
    checks++; if (done_cnt !== base + 1) begin errors++; $display("FAIL par_ok_pulses: got %0d expected 1", done_cnt - base); end
    checks++; if (cap_pe !== 1'b0) begin errors++; $display("FAIL par_ok_perr: got %b expected 0", cap_pe); end
    checks++; if (cap_dout !== 8'h03) begin errors++; $display("FAIL par_ok_dout: got %h expected 03", cap_dout); end
    send_frame(8'h03, 1'b1, 1'b0);
    repeat (64) @(negedge clk);
    checks++; if (done_cnt !== base + 2) begin errors++; $display("FAIL par_bad_pulses: got %0d expected 2", done_cnt - base); end
    checks++; if (cap_pe !== 1'b1) begin errors++; $display("FAIL par_bad_perr: got %b expected 1", cap_pe); end
    checks++; if (cap_dout !== 8'h03) begin errors++; $display("FAIL par_bad_dout: got %h expected 03", cap_dout); end
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_bad_hold: got %b expected 1", parity_err); end
`else
    send_frame(8'h07, 1'b0, 1'b0);
    repeat (64) @(negedge clk);
    checks++; if (done_cnt !== base + 1) begin errors++; $display("FAIL nopar_pulses: got %0d expected 1", done_cnt - base); end
    checks++; if (cap_pe !== 1'b0) begin errors++; $display("FAIL nopar_perr: got %b expected 0", cap_pe); end
    checks++; if (cap_dout !== 8'h07) begin errors++; $display("FAIL nopar_dout: got %h expected 07", cap_dout); end
`endif
  endtask

  task automatic test_frame_err;
    int base;
    base = done_cnt;
    send_frame(8'h55, 1'b0, 1'b1);
    repeat (64) @(negedge clk);
    checks++; if (done_cnt !== base + 1) begin errors++; $display("FAIL ferr_pulses: got %0d expected 1", done_cnt - base); end
    checks++; if (cap_dout !== 8'h55) begin errors++; $display("FAIL ferr_dout: got %h expected 55", cap_dout); end
    checks++; if (cap_fe !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", cap_fe); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_hold: got %b expected 1", frame_err); end
    send_frame(8'h00, 1'b0, 1'b0);
    repeat (64) @(negedge clk);
    checks++; if (done_cnt !== base + 2) begin errors++; $display("FAIL clean_pulses: got %0d expected 2", done_cnt - base); end
    checks++; if (cap_dout !== 8'h00) begin errors++; $display("FAIL clean_dout: got %h expected 00", cap_dout); end
    checks++; if (cap_fe !== 1'b0) begin errors++; $display("FAIL clean_ferr: got %b expected 0", cap_fe); end
  endtask

  task automatic test_back_to_back;
    int base;
    base = done_cnt;
    send_frame(8'h12, 1'b0, 1'b0);
    checks++; if (cap_dout !== 8'h12) begin errors++; $display("FAIL b2b_first_dout: got %h expected 12", cap_dout); end
    send_frame(8'h34, 1'b1, 1'b0);
    repeat (64) @(negedge clk);
    checks++; if (done_cnt !== base + 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", done_cnt - base); end
    checks++; if (cap_dout !== 8'h34) begin errors++; $display("FAIL b2b_second_dout: got %h expected 34", cap_dout); end
    checks++; if (cap_fe !== 1'b0) begin errors++; $display("FAIL b2b_ferr: got %b expected 0", cap_fe); end
  endtask

  task automatic test_reset_mid_frame;
    int base;
    // Leave nonzero dout and a set frame_err so the clearing is visible.
    send_frame(8'hC6, 1'b0, 1'b1);
    repeat (64) @(negedge clk);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL pre_rst_ferr: got %b expected 1", frame_err); end
    base = done_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL midrst_dout: got %h expected 00", dout); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_ferr: got %b expected 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL midrst_perr: got %b expected 0", parity_err); end
    checks++; if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", rx_done_tick); end
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (64) @(negedge clk);
    checks++; if (done_cnt !== base) begin errors++; $display("FAIL midrst_pulses: got %0d expected 0", done_cnt - base); end
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (64) @(negedge clk);
    checks++; if (done_cnt !== base + 1) begin errors++; $display("FAIL post_rst_pulses: got %0d expected 1", done_cnt - base); end
    checks++; if (cap_dout !== 8'h3C) begin errors++; $display("FAIL post_rst_dout: got %h expected 3c", cap_dout); end
    checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL post_rst_hold: got %h expected 3c", dout); end
  endtask

  initial begin
    reset_n = 1'b0;
    rx      = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
